pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch/sequencing controller for the 9-bit ISA core. Owns the program counter, the condition-flag register and the
//  start/done handshake. Consumes decoder outputs (ConditionalJump, BranchAbsOrRel, BranchConditions, Ack) plus ALU
//  compare flags, and drives the instruction ROM address each cycle. Sits between the control decoder and instrROM.
// PARAMETERS
//  PC_W      10     program counter width; ROM depth = 2**PC_W
//  OPND_W     8     branch operand width (register-file data width)
// PORTS
//  Clk              in   1       system clock, all state updates on rising edge
//  Reset            in   1       synchronous, active-high reset
//  Start            in   1       level: hold high to load/park, falling edge launches program
//  StartAddr        in   PC_W    PC value loaded while Start=1 in IDLE/DONE
//  ConditionalJump  in   1       decoded branch instruction
//  BranchAbsOrRel   in   1       0 = absolute target, 1 = PC-relative
//  BranchConditions in   2       00 always, 01 Z=1, 10 Z=0, 11 N=1
//  BranchOperand    in   OPND_W  value of selected branch register (R11..R14)
//  Ack              in   1       decoded halt instruction (9'h1FF)
//  FlagWrEn         in   1       CMP executing: latch flags this cycle
//  ZeroIn           in   1       ALU zero result
//  NegIn            in   1       ALU negative result
//  ProgCtr          out  PC_W    instruction ROM address
//  FetchEn          out  1       1 only in RUN; core commits instructions only when 1
//  BranchTaken      out  1       registered pulse: previous cycle redirected the PC
//  Done             out  1       program halted; held until Start or Reset
//  CycleCount       out  32      (only with CYCLE_COUNT_EN) RUN-cycle counter
// BEHAVIOUR
//  Reset (sync, wins over everything): state=IDLE, ProgCtr=0, Z=N=0, FetchEn=0, BranchTaken=0, Done=0, CycleCount=0.
//  States: IDLE, RUN, DONE. FetchEn = (state==RUN), combinational from state register.
//  IDLE: Start=1 -> ProgCtr<=StartAddr, stay. Start=0 with Start previous cycle=1 (falling edge) -> RUN.
//        Start held 0 from reset -> stay IDLE, ProgCtr holds.
//  RUN, per cycle (priority high->low):
//   1. Start=1      -> IDLE, ProgCtr<=StartAddr (abort/restart), Done stays 0.
//   2. Ack=1        -> DONE, Done<=1, ProgCtr holds (points at halt). Ack overrides ConditionalJump (halt word also
//                      decodes as branch); no branch, no flag update.
//   3. ConditionalJump && cond true -> abs: ProgCtr<=zero-extended BranchOperand;
//                      rel: ProgCtr<=ProgCtr + sign-extended BranchOperand, modulo 2**PC_W (wraps both ways).
//                      BranchTaken<=1 next cycle.
//   4. otherwise    -> ProgCtr<=ProgCtr+1, wraps 2**PC_W-1 -> 0. BranchTaken<=0.
//  Condition evaluated from the REGISTERED flags (pre-update). FlagWrEn same cycle as a branch: branch sees old
//   flags, new flags visible next cycle. FlagWrEn honoured only in RUN and not on Ack cycle.
//  Not-taken conditional branch behaves as case 4. Relative offset 0 = tight loop on self (legal).
//  DONE: Done=1, ProgCtr/flags hold. Start=1 -> IDLE, Done<=0, ProgCtr<=StartAddr.
//  Start edge detect uses a registered copy of Start, reset to 0. Reset mid-RUN: discards state, flags, count.
//  Latency: ProgCtr changes one cycle after the instruction driving it is presented; no bubbles, no stalls.
// CONFIGURATION
//  CYCLE_COUNT_EN defined: CycleCount port present; cleared on IDLE->RUN, +1 every RUN cycle including the Ack
//   cycle, frozen in DONE/IDLE, saturates at 32'hFFFF_FFFF.
//  Not defined: no CycleCount port, no counter logic; all other behaviour identical.
// TESTING
//  T1 reset: Reset=1 for 2 cycles with random inputs -> ProgCtr=0, FetchEn=0, Done=0, BranchTaken=0.
//  T2 launch/linear: StartAddr=10'h005, Start 1 then 0 -> ProgCtr 5,6,7,8 on consecutive cycles, FetchEn=1.
//  T3 branches: PC=20, FlagWrEn Z=1, next cyc cond=01 rel operand 8'hFC -> PC=16, BranchTaken=1; cond=10 same
//     -> not taken, PC=17; abs operand 8'hC8 cond=00 -> PC=200; rel from PC=2 operand 8'hF0 -> PC=10'h3F2.
//  T4 flag hazard: FlagWrEn(Z=1) same cycle as cond=01 branch with prior Z=0 -> not taken, PC+1.
//  T5 halt: Ack=1 with ConditionalJump=1 at PC=30 -> Done=1 next cycle, PC stays 30 for 10 cycles; Start=1 ->
//     Done=0, PC=StartAddr; with CYCLE_COUNT_EN count equals RUN cycles incl. Ack cycle.
//  T6 abort: Start=1 mid-RUN at PC=50 -> IDLE, PC=StartAddr; Reset mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundled decoder/ALU/ROM-side signals of the PC sequencer. CycleCount exists only when
// CYCLE_COUNT_EN is defined.
interface pc_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int OPND_W = 8
);
    logic              Start;
    logic [PC_W-1:0]   StartAddr;
    logic              ConditionalJump;
    logic              BranchAbsOrRel;
    logic [1:0]        BranchConditions;
    logic [OPND_W-1:0] BranchOperand;
    logic              Ack;
    logic              FlagWrEn;
    logic              ZeroIn;
    logic              NegIn;
    logic [PC_W-1:0]   ProgCtr;
    logic              FetchEn;
    logic              BranchTaken;
    logic              Done;
`ifdef CYCLE_COUNT_EN
    logic [31:0]       CycleCount;
`endif

    modport master (
`ifdef CYCLE_COUNT_EN
        input  CycleCount,
`endif
        output Start, StartAddr, ConditionalJump, BranchAbsOrRel, BranchConditions,
        output BranchOperand, Ack, FlagWrEn, ZeroIn, NegIn,
        input  ProgCtr, FetchEn, BranchTaken, Done
    );

    modport slave (
`ifdef CYCLE_COUNT_EN
        output CycleCount,
`endif
        input  Start, StartAddr, ConditionalJump, BranchAbsOrRel, BranchConditions,
        input  BranchOperand, Ack, FlagWrEn, ZeroIn, NegIn,
        output ProgCtr, FetchEn, BranchTaken, Done
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / condition flag / start-done sequencer for the 9-bit ISA core.
// Optional RUN-cycle counter enabled by defining CYCLE_COUNT_EN.
module pc_sequencer #(
    parameter int PC_W   = 10,
    parameter int OPND_W = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            bt_q, bt_d;
    logic            done_q, done_d;
    logic            start_q, start_d;

    function automatic logic cond_true(input logic [1:0] sel, input logic z, input logic n);
        case (sel)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = z;
            2'b10:   cond_true = ~z;
            default: cond_true = n;
        endcase
    endfunction

    // Target wraps modulo 2**PC_W in both directions; offset is two's complement.
    function automatic logic [PC_W-1:0] branch_target(input logic              rel,
                                                      input logic [PC_W-1:0]   pc,
                                                      input logic [OPND_W-1:0] opnd);
        logic signed [PC_W-1:0] offset;
        offset = PC_W'(signed'(opnd));
        if (rel) branch_target = pc + $unsigned(offset);
        else     branch_target = PC_W'(opnd);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        z_d     = z_q;
        n_d     = n_q;
        bt_d    = 1'b0;
        done_d  = done_q;
        start_d = bus.Start;

        case (state_q)
            S_IDLE: begin
                if (bus.Start)    pc_d    = bus.StartAddr;
                else if (start_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.Start) begin
                    state_d = S_IDLE;
                    pc_d    = bus.StartAddr;
                    done_d  = 1'b0;
                end else if (bus.Ack) begin
                    // Halt word also decodes as a branch; it must not redirect or touch flags.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (bus.FlagWrEn) begin
                        z_d = bus.ZeroIn;
                        n_d = bus.NegIn;
                    end
                    // Condition uses the registered flags, so a same-cycle CMP is not yet visible.
                    if (bus.ConditionalJump && cond_true(bus.BranchConditions, z_q, n_q)) begin
                        pc_d = branch_target(bus.BranchAbsOrRel, pc_q, bus.BranchOperand);
                        bt_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus.Start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    pc_d    = bus.StartAddr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            bt_q    <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            n_q     <= n_d;
            bt_q    <= bt_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    assign bus.ProgCtr     = pc_q;
    assign bus.FetchEn     = (state_q == S_RUN);
    assign bus.BranchTaken = bt_q;
    assign bus.Done        = done_q;

`ifdef CYCLE_COUNT_EN
    logic [31:0] cc_q, cc_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counts every cycle spent in RUN, including the halt cycle; restarts on launch.
    always_comb begin
        cc_d = cc_q;
        if (state_q == S_RUN)                           cc_d = sat_inc(cc_q);
        else if (state_q == S_IDLE && state_d == S_RUN) cc_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) cc_q <= '0;
        else       cc_q <= cc_d;
    end

    assign bus.CycleCount = cc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expectations, a negedge monitor checks them.
module tb_pc_sequencer;
    localparam int PC_W   = 10;
    localparam int OPND_W = 8;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    pc_sequencer_if #(.PC_W(PC_W), .OPND_W(OPND_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .OPND_W(OPND_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int              cyc;
        string           name;
        logic [PC_W-1:0] pc;
        logic            fe;
        logic            bt;
        logic            dn;
        logic [31:0]     cc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cc = '0;
    logic        prev_fe = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.cyc != cyc ||
                {bus.ProgCtr, bus.FetchEn, bus.BranchTaken, bus.Done} !== {e.pc, e.fe, e.bt, e.dn}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h fe=%b bt=%b done=%b, want pc=%h fe=%b bt=%b done=%b",
                         e.name, bus.ProgCtr, bus.FetchEn, bus.BranchTaken, bus.Done,
                         e.pc, e.fe, e.bt, e.dn);
            end
`ifdef CYCLE_COUNT_EN
            vectors++;
            if (bus.CycleCount !== e.cc) begin
                miscompares++;
                $display("FAIL %s_count: got %0d, want %0d", e.name, bus.CycleCount, e.cc);
            end
`endif
        end
    end

    task automatic clr();
        bus.Start            = 1'b0;
        bus.ConditionalJump  = 1'b0;
        bus.BranchAbsOrRel   = 1'b0;
        bus.BranchConditions = 2'b00;
        bus.BranchOperand    = '0;
        bus.Ack              = 1'b0;
        bus.FlagWrEn         = 1'b0;
        bus.ZeroIn           = 1'b0;
        bus.NegIn            = 1'b0;
    endtask

    task automatic br(input logic rel, input logic [1:0] c, input logic [7:0] op);
        bus.ConditionalJump  = 1'b1;
        bus.BranchAbsOrRel   = rel;
        bus.BranchConditions = c;
        bus.BranchOperand    = op;
    endtask

    // Push the state expected after the coming clock edge, then advance past that edge.
    task automatic chk(input string nm, input logic [PC_W-1:0] pc,
                       input logic fe, input logic bt, input logic dn);
        exp_t e;
        if (Reset)        exp_cc = '0;
        else if (prev_fe) exp_cc = (exp_cc == 32'hFFFF_FFFF) ? exp_cc : exp_cc + 32'd1;
        else if (fe)      exp_cc = '0;
        prev_fe = fe;
        e.cyc = cyc + 1; e.name = nm; e.pc = pc; e.fe = fe; e.bt = bt; e.dn = dn; e.cc = exp_cc;
        q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // T1: reset with random inputs
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.Start            = 1'($urandom);
            bus.StartAddr        = PC_W'($urandom);
            bus.ConditionalJump  = 1'($urandom);
            bus.BranchAbsOrRel   = 1'($urandom);
            bus.BranchConditions = 2'($urandom);
            bus.BranchOperand    = 8'($urandom);
            bus.Ack              = 1'($urandom);
            bus.FlagWrEn         = 1'($urandom);
            bus.ZeroIn           = 1'($urandom);
            bus.NegIn            = 1'($urandom);
            chk("reset", 10'd0, 1'b0, 1'b0, 1'b0);
        end
        Reset = 1'b0;
        clr();
        chk("idle_hold", 10'd0, 1'b0, 1'b0, 1'b0);

        // T2: launch and linear fetch
        bus.Start = 1'b1; bus.StartAddr = 10'h005;
        chk("load", 10'd5, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b0;
        chk("launch", 10'd5, 1'b1, 1'b0, 1'b0);
        chk("lin6", 10'd6, 1'b1, 1'b0, 1'b0);
        chk("lin7", 10'd7, 1'b1, 1'b0, 1'b0);
        chk("lin8", 10'd8, 1'b1, 1'b0, 1'b0);

        // T3: branches
        br(1'b0, 2'b00, 8'd19);             chk("abs19", 10'd19, 1'b1, 1'b1, 1'b0);
        clr(); bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1;
        chk("flag_z", 10'd20, 1'b1, 1'b0, 1'b0);
        clr(); br(1'b1, 2'b01, 8'hFC);      chk("rel_z", 10'd16, 1'b1, 1'b1, 1'b0);
        br(1'b1, 2'b10, 8'hFC);             chk("nz_not", 10'd17, 1'b1, 1'b0, 1'b0);
        br(1'b0, 2'b00, 8'hC8);             chk("abs200", 10'd200, 1'b1, 1'b1, 1'b0);
        br(1'b0, 2'b00, 8'h02);             chk("abs2", 10'd2, 1'b1, 1'b1, 1'b0);
        br(1'b1, 2'b00, 8'hF0);             chk("rel_back", 10'h3F2, 1'b1, 1'b1, 1'b0);
        clr(); bus.FlagWrEn = 1'b1; bus.NegIn = 1'b1;
        chk("flag_n", 10'h3F3, 1'b1, 1'b0, 1'b0);
        clr(); br(1'b1, 2'b11, 8'h00);      chk("self_loop", 10'h3F3, 1'b1, 1'b1, 1'b0);
        br(1'b1, 2'b00, 8'h0C);             chk("rel_3ff", 10'h3FF, 1'b1, 1'b1, 1'b0);
        clr();                              chk("wrap", 10'd0, 1'b1, 1'b0, 1'b0);

        // T4: same-cycle flag write does not affect the branch
        bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1; br(1'b1, 2'b01, 8'hFC);
        chk("hazard", 10'd1, 1'b1, 1'b0, 1'b0);
        clr(); br(1'b1, 2'b01, 8'h05);      chk("new_z", 10'd6, 1'b1, 1'b1, 1'b0);

        // T5: halt overrides branch, holds, restarts
        br(1'b0, 2'b00, 8'd30);             chk("abs30", 10'd30, 1'b1, 1'b1, 1'b0);
        br(1'b0, 2'b00, 8'h10); bus.Ack = 1'b1;
        bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b0; bus.NegIn = 1'b1;
        chk("halt", 10'd30, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            br(1'($urandom), 2'($urandom), 8'($urandom));
            bus.Ack = 1'($urandom); bus.FlagWrEn = 1'($urandom);
            chk("done_hold", 10'd30, 1'b0, 1'b0, 1'b1);
        end
        clr(); bus.Start = 1'b1; bus.StartAddr = 10'h040;
        chk("restart", 10'h040, 1'b0, 1'b0, 1'b0);
        bus.StartAddr = 10'h041;
        chk("reload", 10'h041, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b0;
        chk("relaunch", 10'h041, 1'b1, 1'b0, 1'b0);
        br(1'b1, 2'b01, 8'h03);             chk("z_kept", 10'h044, 1'b1, 1'b1, 1'b0);
        br(1'b1, 2'b11, 8'h03);             chk("n_kept", 10'h045, 1'b1, 1'b0, 1'b0);

        // T6: abort and mid-run reset
        br(1'b0, 2'b00, 8'd50);             chk("abs50", 10'd50, 1'b1, 1'b1, 1'b0);
        clr(); bus.Start = 1'b1; bus.StartAddr = 10'h077;
        chk("abort", 10'h077, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b0;
        chk("abort_run", 10'h077, 1'b1, 1'b0, 1'b0);
        chk("lin78", 10'h078, 1'b1, 1'b0, 1'b0);
        br(1'b0, 2'b00, 8'h20);             chk("abs20", 10'h020, 1'b1, 1'b1, 1'b0);
        Reset = 1'b1; br(1'b0, 2'b00, 8'h30); bus.FlagWrEn = 1'b1; bus.ZeroIn = 1'b1;
        chk("rst_mid", 10'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0; clr();
        chk("post_rst", 10'd0, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b1; bus.StartAddr = 10'h000;
        chk("load0", 10'd0, 1'b0, 1'b0, 1'b0);
        bus.Start = 1'b0;
        chk("launch0", 10'd0, 1'b1, 1'b0, 1'b0);
        br(1'b1, 2'b01, 8'h05);             chk("z_cleared", 10'd1, 1'b1, 1'b0, 1'b0);
        clr();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
